// File: rtl/pitch_pkg.sv
// Shared types for the pitch background renderer: colours,
// the flash FSM states, the signed coordinate type and the stage-1 bundle.
package pitch_pkg;

  typedef logic [7:0] rgb332_t;

  localparam rgb332_t BLACK       = 8'h00;
  localparam rgb332_t WHITE       = 8'hFF;
  localparam rgb332_t NET_FLASH   = 8'hFC;
  localparam rgb332_t GRASS_DARK  = 8'h0C;
  localparam rgb332_t GRASS_LIGHT = 8'h4C;

  typedef enum logic [1:0] {
    IDLE,
    FLASH_TEAM,
    FLASH_OPP
  } flash_state_t;

  // Signed so that rows above a goal top (top - margin) may go negative.
  typedef logic signed [12:0] coord_t;

  typedef struct packed {
    logic               vis;
    logic               opp_back;
    logic               team_back;
    logic               opp_net;
    logic               team_net;
    logic               in_field;
    logic               line;
    logic               mark;
    logic               stripe;
    logic signed [11:0] dx;
    logic signed [11:0] dy;
  } s1_t;

  function automatic coord_t to_coord(input logic [10:0] v);
    return $signed({2'b00, v});
  endfunction

  // Three-sided box open on the goal line at column xg:
  // far side at column xe, top/bottom rows y0/y1.
  function automatic logic box3(
    input coord_t x,
    input coord_t y,
    input coord_t xg,
    input coord_t xe,
    input coord_t y0,
    input coord_t y1
  );
    coord_t lo;
    coord_t hi;
    lo = (xg < xe) ? xg : xe;
    hi = (xg < xe) ? xe : xg;
    return (x == xe && y >= y0 && y <= y1) ||
           ((y == y0 || y == y1) && x >= lo && x <= hi);
  endfunction

endpackage

// File: rtl/pitch_bg_renderer_goal_flash_fsm.sv
// Goal-celebration flash engine: state, frame countdown, blink phase.
// Ports: clk, reset, startOfFrame/score pulses in; state, phase, active out.
module goal_flash_fsm
  import pitch_pkg::*;
#(
  parameter int FLASH_FRAMES = 60,
  parameter int FLASH_PERIOD = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_of_frame_i,
  input  logic         team_scored_i,
  input  logic         opp_scored_i,
  output flash_state_t state_o,
  output logic         phase_o,
  output logic         active_o
);

  localparam int CW = $clog2(FLASH_FRAMES + 1);
  localparam int PW =
    (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

  flash_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] per_q, per_d;
  logic          phase_q, phase_d;
  logic          active_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    phase_d = phase_q;
    if (team_scored_i || opp_scored_i) begin
      // Any new goal restarts the celebration; team wins a tie.
      state_d = team_scored_i ? FLASH_TEAM : FLASH_OPP;
      cnt_d   = CW'(FLASH_FRAMES);
      per_d   = '0;
      phase_d = 1'b0;
    end else if (state_q != IDLE && start_of_frame_i) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        per_d   = '0;
        phase_d = 1'b0;
      end else if (per_q == PW'(FLASH_PERIOD - 1)) begin
        per_d   = '0;
        phase_d = ~phase_q;
      end else begin
        per_d = per_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      per_q    <= '0;
      phase_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      phase_q  <= phase_d;
      active_q <= (state_d != IDLE);
    end
  end

  assign state_o  = state_q;
  assign phase_o  = phase_q;
  assign active_o = active_q;

endmodule

// File: rtl/pitch_bg_renderer.sv
// Two-stage pitch background renderer with goal-flash engine.
// In: clk, reset, pixelX/Y, startOfFrame, goal tops, score pulses.
// Out: BG_RGB, boardersDrawReq, team/oppGoalDrawReq, flashActive.
// Option: GRASS_STRIPES_EN selects 32-column striped grass.
module pitch_bg_renderer
  import pitch_pkg::*;
#(
  parameter int X_MAX        = 635,
  parameter int Y_MAX        = 475,
  parameter int BORDER       = 30,
  parameter int GOAL_DEPTH   = 32,
  parameter int GOAL_H       = 64,
  parameter int BOX_S        = 20,
  parameter int BOX_L        = 60,
  parameter int MID_X        = 315,
  parameter int MID_Y        = 237,
  parameter int CIRCLE_R     = 50,
  parameter int FLASH_FRAMES = 60,
  parameter int FLASH_PERIOD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic [10:0] teamGoalTop,
  input  logic [10:0] oppGoalTop,
  input  logic        teamScored,
  input  logic        oppScored,
  output logic [7:0]  BG_RGB,
  output logic        boardersDrawReq,
  output logic        teamGoalDrawReq,
  output logic        oppGoalDrawReq,
  output logic        flashActive
);

  localparam coord_t XM   = coord_t'(X_MAX);
  localparam coord_t YM   = coord_t'(Y_MAX);
  localparam coord_t FL   = coord_t'(BORDER);
  localparam coord_t FR   = coord_t'(X_MAX - BORDER);
  localparam coord_t FT   = coord_t'(BORDER);
  localparam coord_t FB   = coord_t'(Y_MAX - BORDER);
  localparam coord_t OBX  = coord_t'(5);
  localparam coord_t TBX  = coord_t'(X_MAX - 3);
  localparam coord_t GD   = coord_t'(GOAL_DEPTH);
  localparam coord_t GH   = coord_t'(GOAL_H);
  localparam coord_t BS   = coord_t'(BOX_S);
  localparam coord_t BL   = coord_t'(BOX_L);
  localparam coord_t SM   = coord_t'(10);
  localparam coord_t LM   = coord_t'(50);
  localparam coord_t SPX  = coord_t'(42);
  localparam coord_t SPY  = coord_t'(32);
  localparam coord_t MX   = coord_t'(MID_X);
  localparam coord_t MY   = coord_t'(MID_Y);
  localparam int     R2   = CIRCLE_R * CIRCLE_R;
  localparam int     RI2  = (CIRCLE_R - 1) * (CIRCLE_R - 1);

  flash_state_t fsm_state;
  logic         fsm_phase;

  goal_flash_fsm #(
    .FLASH_FRAMES(FLASH_FRAMES),
    .FLASH_PERIOD(FLASH_PERIOD)
  ) u_flash (
    .clk             (clk),
    .reset           (reset),
    .start_of_frame_i(startOfFrame),
    .team_scored_i   (teamScored),
    .opp_scored_i    (oppScored),
    .state_o         (fsm_state),
    .phase_o         (fsm_phase),
    .active_o        (flashActive)
  );

  // Stage 1: geometry compares and circle offsets.
  coord_t x, y, ot, tt, ot_b, tt_b;
  logic   opp_mouth, team_mouth, spots, boxes;
  s1_t    s1_d, s1_q;

  always_comb begin
    x    = to_coord(pixelX);
    y    = to_coord(pixelY);
    ot   = to_coord(oppGoalTop);
    tt   = to_coord(teamGoalTop);
    ot_b = ot + GH;
    tt_b = tt + GH;

    opp_mouth  = (y > ot) && (y < ot_b);
    team_mouth = (y > tt) && (y < tt_b);

    boxes = box3(x, y, FL, FL + BS, ot - SM, ot_b + SM) ||
            box3(x, y, FL, FL + BL, ot - LM, ot_b + LM) ||
            box3(x, y, FR, FR - BS, tt - SM, tt_b + SM) ||
            box3(x, y, FR, FR - BL, tt - LM, tt_b + LM);

    spots = (x >= FL + SPX && x <= FL + SPX + 1 &&
             y >= ot + SPY && y <= ot + SPY + 1) ||
            (x >= FR - SPX - 1 && x <= FR - SPX &&
             y >= tt + SPY && y <= tt + SPY + 1);

    s1_d           = '0;
    s1_d.vis       = (x <= XM) && (y <= YM);
    s1_d.opp_back  = (x == OBX) && (y >= ot) && (y <= ot_b);
    s1_d.team_back = (x == TBX) && (y >= tt) && (y <= tt_b);
    s1_d.opp_net   = (x > OBX) && (x < OBX + GD) &&
                     (y == ot || y == ot_b);
    s1_d.team_net  = (x > TBX - GD) && (x < TBX) &&
                     (y == tt || y == tt_b);
    s1_d.in_field  = (x >= FL) && (x <= FR) &&
                     (y >= FT) && (y <= FB);
    s1_d.line      = (x == FL && !opp_mouth) ||
                     (x == FR && !team_mouth) ||
                     (y == FT) || (y == FB);
    s1_d.mark      = boxes || spots || (x == MX);
    s1_d.stripe    = pixelX[5];
    s1_d.dx        = 12'(x - MX);
    s1_d.dy        = 12'(y - MY);
  end

  // Stage 2: circle distance and colour priority mux.
  logic signed [11:0] dx_s, dy_s;
  logic signed [23:0] dx2, dy2;
  logic        [23:0] d2;
  logic               circ;
  rgb332_t            opp_col, team_col, grass;
  rgb332_t            rgb_d, rgb_q;
  logic               bord_d, bord_q;
  logic               team_d, team_q;
  logic               opp_d, opp_q;

  always_comb begin
    dx_s = s1_q.dx;
    dy_s = s1_q.dy;
    dx2  = dx_s * dx_s;
    dy2  = dy_s * dy_s;
    d2   = $unsigned(dx2) + $unsigned(dy2);
    circ = (d2 > 24'(RI2)) && (d2 <= 24'(R2));

    opp_col  = (fsm_state == FLASH_OPP && fsm_phase)
             ? NET_FLASH : BLACK;
    team_col = (fsm_state == FLASH_TEAM && fsm_phase)
             ? NET_FLASH : BLACK;
`ifdef GRASS_STRIPES_EN
    grass = s1_q.stripe ? GRASS_LIGHT : GRASS_DARK;
`else
    grass = GRASS_DARK;
`endif

    rgb_d  = BLACK;
    bord_d = 1'b0;
    team_d = 1'b0;
    opp_d  = 1'b0;
    if (!s1_q.vis) begin
      rgb_d = BLACK;
    end else if (s1_q.opp_back) begin
      rgb_d = opp_col;
      opp_d = 1'b1;
    end else if (s1_q.team_back) begin
      rgb_d  = team_col;
      team_d = 1'b1;
    end else if (s1_q.opp_net || s1_q.team_net) begin
      rgb_d  = s1_q.opp_net ? opp_col : team_col;
      bord_d = 1'b1;
    end else if (!s1_q.in_field) begin
      rgb_d = BLACK;
    end else if (s1_q.line) begin
      rgb_d  = WHITE;
      bord_d = 1'b1;
    end else if (s1_q.mark || circ) begin
      rgb_d = WHITE;
    end else begin
      rgb_d = grass;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      rgb_q  <= BLACK;
      bord_q <= 1'b0;
      team_q <= 1'b0;
      opp_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      rgb_q  <= rgb_d;
      bord_q <= bord_d;
      team_q <= team_d;
      opp_q  <= opp_d;
    end
  end

  assign BG_RGB          = rgb_q;
  assign boardersDrawReq = bord_q;
  assign teamGoalDrawReq = team_q;
  assign oppGoalDrawReq  = opp_q;

endmodule
